// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_pkg
//  Description : Shared constants and types for the microsequencer
//                next-state logic: address width, next-state mode codes,
//                condition-select codes and the opcode-to-start-state table.
//  Revision    : 1.0  initial release
// ============================================================================
package control_pkg;

  // Control-store address width.
  localparam int ADDR_W = 10;

  // Next-state mode field of the control word.
  typedef enum logic [2:0] {
    NS_INCR    = 3'd0,
    NS_JUMP    = 3'd1,
    NS_DECODE  = 3'd2,
    NS_CBRANCH = 3'd3,
    NS_WAIT    = 3'd4,
    NS_CALL    = 3'd5,
    NS_RETURN  = 3'd6,
    NS_FETCH   = 3'd7
  } ns_mode_e;

  // Condition-select field of the control word.
  typedef enum logic [2:0] {
    COND_MOC    = 3'd0,
    COND_Z      = 3'd1,
    COND_N      = 3'd2,
    COND_C      = 3'd3,
    COND_V      = 3'd4,
    COND_BRPASS = 3'd5,
    COND_ONE    = 3'd6,
    COND_ZERO   = 3'd7
  } cond_sel_e;

  // Bit positions inside the {N,Z,C,V} flag vector.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // One opcode-to-start-state mapping; entries with valid=0 are ignored.
  typedef struct packed {
    logic              valid;
    logic [7:0]        op;
    logic [ADDR_W-1:0] addr;
  } enc_entry_t;

  localparam int ENC_N = 8;

  // Opcodes not listed here are unmapped and decode as illegal.
  localparam enc_entry_t ENC_TABLE [ENC_N] = '{
    '{1'b1, 8'h0A, 10'd10},
    '{1'b1, 8'h01, 10'd200},
    '{1'b1, 8'h02, 10'd300},
    '{1'b1, 8'h10, 10'd400},
    '{1'b1, 8'h20, 10'd500},
    '{1'b1, 8'h30, 10'd600},
    '{1'b1, 8'h40, 10'd700},
    '{1'b1, 8'hF0, 10'd900}
  };

endpackage
`default_nettype wire

// File: rtl/next_state_selector_if.sv
`default_nettype none
// ============================================================================
//  Module      : next_state_selector_if
//  Description : Control-word fields, status inputs and sequencer outputs
//                of the next-state selector, bundled for port connection.
//  Revision    : 1.0  initial release
// ============================================================================
interface next_state_selector_if #(
  parameter int ADDR_W = control_pkg::ADDR_W
) ();

  logic              enable;
  logic [2:0]        ns_mode;
  logic [2:0]        cond_sel;
  logic              inv;
  logic [ADDR_W-1:0] cr_addr;
  logic              moc;
  logic [3:0]        flags;
  logic              br_pass;
  logic [7:0]        ir_op;
  logic [ADDR_W-1:0] next_state;
  logic              stack_err;
  logic              illegal_op;

  // Drives the control word and status, observes the sequencer.
  modport master (
    output enable, ns_mode, cond_sel, inv, cr_addr, moc, flags, br_pass, ir_op,
    input  next_state, stack_err, illegal_op
  );

  // The sequencer itself.
  modport slave (
    input  enable, ns_mode, cond_sel, inv, cr_addr, moc, flags, br_pass, ir_op,
    output next_state, stack_err, illegal_op
  );

endinterface
`default_nettype wire

// File: rtl/instruction_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_encoder
//  Description : Combinational opcode-to-start-state lookup against
//                ENC_TABLE; o_valid low marks an unmapped opcode.
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_encoder #(
  parameter int ADDR_W = control_pkg::ADDR_W
) (
  input  wire logic [7:0]        i_ir_op,
  output logic      [ADDR_W-1:0] o_addr,
  output logic                   o_valid
);
  import control_pkg::*;

  // Scan the table; opcodes are unique so at most one entry matches.
  always_comb begin
    o_addr  = '0;
    o_valid = 1'b0;
    for (int i = 0; i < ENC_N; i++) begin
      if (ENC_TABLE[i].valid && (ENC_TABLE[i].op == i_ir_op)) begin
        o_addr  = ADDR_W'(ENC_TABLE[i].addr);
        o_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/next_state_selector.sv
`default_nettype none
// ============================================================================
//  Module      : next_state_selector
//  Description : Microsequencer next-state logic. Selects the next control
//                store address from increment, jump, opcode decode,
//                conditional branch, wait, call/return (LIFO stack) or
//                fetch, and registers it with one cycle of latency.
//  Revision    : 1.0  initial release
// ============================================================================
module next_state_selector #(
  parameter int ADDR_W      = control_pkg::ADDR_W,
  parameter int STACK_DEPTH = 4
) (
  input wire logic             clk,
  input wire logic             reset,
  next_state_selector_if.slave bus
);
  import control_pkg::*;

  // Pointer counts 0..STACK_DEPTH, so it needs one more code than the index.
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] c_SP_FULL = SP_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] r_next_state;
  logic [SP_W-1:0]   r_sp;
  logic              r_stack_err;
  logic              r_illegal_op;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  logic              w_cond_raw;
  logic              w_cond;
  logic [ADDR_W-1:0] w_inc;
  logic [ADDR_W-1:0] w_enc_addr;
  logic              w_enc_valid;
  logic [ADDR_W-1:0] w_top;
  logic              w_full;
  logic              w_empty;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [ADDR_W-1:0] w_ns_d;
  logic              w_push;
  logic              w_pop;
  logic              w_err_set;
  logic              w_illegal_d;

  instruction_encoder #(
    .ADDR_W (ADDR_W)
  ) u_encoder (
    .i_ir_op (bus.ir_op),
    .o_addr  (w_enc_addr),
    .o_valid (w_enc_valid)
  );

  assign w_inc    = r_next_state + ADDR_W'(1);
  assign w_full   = (r_sp == c_SP_FULL);
  assign w_empty  = (r_sp == '0);
  assign w_wr_idx = IDX_W'(r_sp);
  assign w_rd_idx = IDX_W'(r_sp - SP_W'(1));
  assign w_top    = r_stack[w_rd_idx];
  assign w_cond   = w_cond_raw ^ bus.inv;

  // Condition multiplexer ahead of the invert.
  always_comb begin
    w_cond_raw = 1'b0;
    case (cond_sel_e'(bus.cond_sel))
      COND_MOC:    w_cond_raw = bus.moc;
      COND_Z:      w_cond_raw = bus.flags[FLAG_Z];
      COND_N:      w_cond_raw = bus.flags[FLAG_N];
      COND_C:      w_cond_raw = bus.flags[FLAG_C];
      COND_V:      w_cond_raw = bus.flags[FLAG_V];
      COND_BRPASS: w_cond_raw = bus.br_pass;
      COND_ONE:    w_cond_raw = 1'b1;
      COND_ZERO:   w_cond_raw = 1'b0;
      default:     w_cond_raw = 1'b0;
    endcase
  end

  // Next-address selection plus stack push/pop and error requests.
  always_comb begin
    w_ns_d      = r_next_state;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_err_set   = 1'b0;
    w_illegal_d = 1'b0;
    case (ns_mode_e'(bus.ns_mode))
      NS_INCR:    w_ns_d = w_inc;
      NS_JUMP:    w_ns_d = bus.cr_addr;
      NS_DECODE: begin
        if (w_enc_valid) begin
          w_ns_d = w_enc_addr;
        end else begin
          w_ns_d      = '0;
          w_illegal_d = 1'b1;
        end
      end
      NS_CBRANCH: w_ns_d = w_cond ? bus.cr_addr : w_inc;
      // Stall in place until the condition (normally moc) comes true.
      NS_WAIT:    w_ns_d = w_cond ? w_inc : r_next_state;
      NS_CALL: begin
        // The jump still happens on overflow; only the return address is lost.
        w_ns_d = bus.cr_addr;
        if (w_full) begin
          w_err_set = 1'b1;
        end else begin
          w_push = 1'b1;
        end
      end
      NS_RETURN: begin
        if (w_empty) begin
          w_ns_d    = '0;
          w_err_set = 1'b1;
        end else begin
          w_ns_d = w_top;
          w_pop  = 1'b1;
        end
      end
      NS_FETCH:   w_ns_d = '0;
      default:    w_ns_d = '0;
    endcase
  end

  // Address register, stack pointer and status; enable low freezes all state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_next_state <= '0;
      r_sp         <= '0;
      r_stack_err  <= 1'b0;
      r_illegal_op <= 1'b0;
    end else if (bus.enable) begin
      r_next_state <= w_ns_d;
      if (w_push) begin
        r_sp <= r_sp + SP_W'(1);
      end else if (w_pop) begin
        r_sp <= r_sp - SP_W'(1);
      end
      if (w_err_set) begin
        r_stack_err <= 1'b1;
      end
      r_illegal_op <= w_illegal_d;
    end else begin
      r_illegal_op <= 1'b0;
    end
  end

  // Stack storage; only the pointer is reset, entry contents are don't-care.
  always_ff @(posedge clk) begin
    if (reset && bus.enable && w_push) begin
      r_stack[w_wr_idx] <= w_inc;
    end
  end

  assign bus.next_state = r_next_state;
  assign bus.stack_err  = r_stack_err;
  assign bus.illegal_op = r_illegal_op;

endmodule
`default_nettype wire

// File: tb/tb_next_state_selector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_next_state_selector
//  Description : Directed self-checking bench for next_state_selector.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_next_state_selector;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  next_state_selector_if #(.ADDR_W(10)) bus ();

  next_state_selector #(
    .ADDR_W      (10),
    .STACK_DEPTH (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic       inv;
    logic       moc;
    logic [3:0] flags;
    logic       brp;
    logic       taken;
  } br_vec_t;

  // Conditional-branch vectors from state 20 to target 80; flags = {N,Z,C,V}.
  br_vec_t br_tab [14] = '{
    '{3'd1, 1'b0, 1'b0, 4'b0100, 1'b0, 1'b1},
    '{3'd1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0},
    '{3'd1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1},
    '{3'd1, 1'b0, 1'b1, 4'b1011, 1'b1, 1'b0},
    '{3'd0, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b1},
    '{3'd2, 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1},
    '{3'd2, 1'b0, 1'b1, 4'b0111, 1'b1, 1'b0},
    '{3'd3, 1'b0, 1'b0, 4'b0010, 1'b0, 1'b1},
    '{3'd4, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1},
    '{3'd4, 1'b0, 1'b1, 4'b1110, 1'b1, 1'b0},
    '{3'd5, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1},
    '{3'd5, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0},
    '{3'd6, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1},
    '{3'd7, 1'b0, 1'b1, 4'b1111, 1'b1, 1'b0}
  };

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] mode, input logic [9:0] addr);
    bus.ns_mode = mode;
    bus.cr_addr = addr;
  endtask

  task automatic jump_to(input logic [9:0] a);
    drive(3'd1, a);
    step();
    check("jump", 32'(bus.next_state), 32'(a));
  endtask

  initial begin
    reset        = 1'b0;
    bus.enable   = 1'b1;
    bus.ns_mode  = 3'd1;
    bus.cr_addr  = 10'd55;
    bus.cond_sel = 3'd0;
    bus.inv      = 1'b0;
    bus.moc      = 1'b0;
    bus.flags    = 4'b0000;
    bus.br_pass  = 1'b0;
    bus.ir_op    = 8'h00;

    // Reset held two cycles with JUMP 55 on the control word.
    step();
    check("rst_ns_c1", 32'(bus.next_state), 32'd0);
    check("rst_err", 32'(bus.stack_err), 32'd0);
    check("rst_ill", 32'(bus.illegal_op), 32'd0);
    step();
    check("rst_ns_c2", 32'(bus.next_state), 32'd0);
    reset = 1'b1;
    check("rel_ns", 32'(bus.next_state), 32'd0);
    step();
    check("jump55", 32'(bus.next_state), 32'd55);

    // FETCH returns to 0.
    drive(3'd7, 10'd0);
    step();
    check("fetch", 32'(bus.next_state), 32'd0);

    // DECODE: mapped then unmapped opcode.
    drive(3'd2, 10'd0);
    bus.ir_op = 8'h0A;
    step();
    check("dec_ns", 32'(bus.next_state), 32'd10);
    check("dec_ill", 32'(bus.illegal_op), 32'd0);
    bus.ir_op = 8'h20;
    step();
    check("dec_ns2", 32'(bus.next_state), 32'd500);
    bus.ir_op = 8'h77;
    step();
    check("bad_ns", 32'(bus.next_state), 32'd0);
    check("bad_ill", 32'(bus.illegal_op), 32'd1);
    drive(3'd0, 10'd0);
    step();
    check("bad_ill_end", 32'(bus.illegal_op), 32'd0);
    check("incr_after", 32'(bus.next_state), 32'd1);

    // WAIT on moc from 42.
    jump_to(10'd42);
    drive(3'd4, 10'd0);
    bus.cond_sel = 3'd0;
    bus.inv      = 1'b0;
    bus.moc      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_hold", 32'(bus.next_state), 32'd42);
    end
    bus.moc = 1'b1;
    step();
    check("wait_go", 32'(bus.next_state), 32'd43);
    bus.moc = 1'b0;

    // Conditional branches from 20 to 80.
    for (int i = 0; i < 14; i++) begin
      jump_to(10'd20);
      bus.cond_sel = br_tab[i].sel;
      bus.inv      = br_tab[i].inv;
      bus.moc      = br_tab[i].moc;
      bus.flags    = br_tab[i].flags;
      bus.br_pass  = br_tab[i].brp;
      drive(3'd3, 10'd80);
      step();
      check($sformatf("cbr_%0d", i), 32'(bus.next_state), br_tab[i].taken ? 32'd80 : 32'd21);
    end
    bus.inv = 1'b0; bus.moc = 1'b0; bus.flags = 4'b0000; bus.br_pass = 1'b0;

    // Five nested calls from 100..104; the fifth overflows.
    jump_to(10'd100);
    for (int i = 0; i < 5; i++) begin
      drive(3'd5, 10'(101 + i));
      step();
      check($sformatf("call_ns_%0d", i), 32'(bus.next_state), 32'(101 + i));
      check($sformatf("call_err_%0d", i), 32'(bus.stack_err), (i == 4) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(3'd6, 10'd0);
      step();
      check($sformatf("ret_ns_%0d", i), 32'(bus.next_state), (i < 4) ? 32'(104 - i) : 32'd0);
    end
    check("ret_err_sticky", 32'(bus.stack_err), 32'd1);

    // Wrap at the top of the address space.
    jump_to(10'd1023);
    drive(3'd0, 10'd0);
    step();
    check("wrap", 32'(bus.next_state), 32'd0);

    // Enable low freezes state and suppresses illegal_op.
    jump_to(10'd7);
    bus.enable = 1'b0;
    drive(3'd0, 10'd0);
    step();
    check("en_hold", 32'(bus.next_state), 32'd7);
    drive(3'd2, 10'd0);
    bus.ir_op = 8'h77;
    step();
    check("en_hold_dec", 32'(bus.next_state), 32'd7);
    check("en_no_ill", 32'(bus.illegal_op), 32'd0);
    check("en_err_held", 32'(bus.stack_err), 32'd1);
    bus.enable = 1'b1;
    drive(3'd0, 10'd0);
    step();
    check("en_resume", 32'(bus.next_state), 32'd8);

    // Reset during a call chain and a wait abandons everything.
    jump_to(10'd300);
    drive(3'd5, 10'd400);
    step();
    check("pre_rst_call", 32'(bus.next_state), 32'd400);
    drive(3'd4, 10'd0);
    bus.cond_sel = 3'd0;
    bus.moc      = 1'b0;
    step();
    check("pre_rst_wait", 32'(bus.next_state), 32'd400);
    reset = 1'b0;
    step();
    check("mid_rst_ns", 32'(bus.next_state), 32'd0);
    check("mid_rst_err", 32'(bus.stack_err), 32'd0);
    reset = 1'b1;
    check("mid_rel_ns", 32'(bus.next_state), 32'd0);
    drive(3'd6, 10'd0);
    step();
    check("post_rst_ret", 32'(bus.next_state), 32'd0);
    check("post_rst_uflow", 32'(bus.stack_err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/next_state_selector.md
NEXT_STATE_SELECTOR -- requirements
Module: next_state_selector

Interface
REQ-001 Parameter ADDR_W, default 10: control-state address width.
REQ-002 Parameter STACK_DEPTH, default 4: micro-return stack entries.
REQ-003 clk  in  1  single clock; all state updates occur on the rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 enable  in  1  advance enable; low freezes all state.
REQ-006 ns_mode  in  3  next-state mode field from the current control word.
REQ-007 cond_sel  in  3  condition select field from the current control word.
REQ-008 inv  in  1  condition invert field.
REQ-009 cr_addr  in  ADDR_W  jump/call target field from the current control word.
REQ-010 moc  in  1  memory-operation-complete from memory interface.
REQ-011 flags  in  4  condition codes {N,Z,C,V}.
REQ-012 br_pass  in  1  branch-condition-evaluator result.
REQ-013 ir_op  in  8  opcode byte of the instruction register.
REQ-014 next_state  out  ADDR_W  registered address that drives the control store.
REQ-015 stack_err  out  1  sticky stack overflow/underflow flag.
REQ-016 illegal_op  out  1  one-cycle pulse on DECODE of an unmapped opcode.

Function
REQ-017 next_state SHALL be registered; value selected in cycle n appears after edge n, giving 1-cycle latency from control word to address.
REQ-018 cond = mux(cond_sel: 0 moc, 1 Z, 2 N, 3 C, 4 V, 5 br_pass, 6 constant 1, 7 constant 0) XOR inv.
REQ-019 inc = next_state + 1, modulo 2^ADDR_W; 1023 wraps to 0.
REQ-020 ns_mode 0 INCR: load inc.
REQ-021 ns_mode 1 JUMP: load cr_addr.
REQ-022 ns_mode 2 DECODE: load encoder address for ir_op.
REQ-023 DECODE with an unmapped ir_op: load 0 and pulse illegal_op for one cycle.
REQ-024 ns_mode 3 CBRANCH: load cr_addr if cond, else inc.
REQ-025 ns_mode 4 WAIT: load inc if cond, else hold next_state (memory handshake stall on moc).
REQ-026 ns_mode 5 CALL: push inc, load cr_addr.
REQ-027 CALL with stack full: drop the push, still load cr_addr, set stack_err.
REQ-028 ns_mode 6 RETURN: pop, load popped address.
REQ-029 RETURN with stack empty: load 0, set stack_err.
REQ-030 ns_mode 7 FETCH: load 0.
REQ-031 Stack is LIFO, depth STACK_DEPTH, with a pointer 0..STACK_DEPTH; at most one push or pop per cycle.
REQ-032 enable low: next_state, stack, pointer and stack_err held; illegal_op held low.
REQ-033 stack_err clears only on reset.

Reset
REQ-034 reset low at a rising edge forces next_state=0, stack pointer=0, stack_err=0 and illegal_op=0, overriding enable and ns_mode.
REQ-035 Stack entry contents are don't-care after reset.
REQ-036 Reset mid-WAIT or mid-call-chain abandons all pending state; the first cycle after release presents state 0.

Structure
REQ-037 Shared package control_pkg SHALL hold ADDR_W, NS_* mode codes, COND_* select codes and ENC_TABLE (opcode-to-start-state map plus valid bit).
REQ-038 Opcode mapping SHALL live in sub-module instruction_encoder (combinational: ir_op in; address and valid out).
REQ-039 The stack SHALL be implemented inside next_state_selector.

Verification
REQ-040 Reset scenario: reset low 2 cycles with ns_mode=1, cr_addr=55 -> next_state=0 while reset low and in the first cycle after release.
REQ-041 Decode scenario: ns_mode=2 with ENC_TABLE-mapped ir_op (e.g. 10) -> next_state=10 next cycle; unmapped ir_op -> next_state=0 and illegal_op high exactly one cycle.
REQ-042 Wait scenario: next_state=42, ns_mode=4, cond_sel=0, inv=0, moc low 3 cycles then high -> next_state stays 42 for 3 cycles, then 43.
REQ-043 Branch scenario: ns_mode=3, cond_sel=1, cr_addr=80, next_state=20: Z=1 -> 80; Z=0 -> 21; Z=0 with inv=1 -> 80.
REQ-044 Stack scenario: 5 nested CALLs from states 100..104 -> 5th sets stack_err; 5 RETURNs -> 104, 103, 102, 101, then 0 (underflow).
REQ-045 Wrap/enable scenario: next_state=1023 with INCR -> 0; enable low with INCR -> next_state unchanged.
